tx_ram_writer: RTL and testbench

- Write-side controller for the TX distributed SDP RAM: accepts a framed 64-bit stream and drives the RAM write port (wr_data/wr_addr/wr_en) as a circular buffer.
- Publishes a committed write pointer only once a whole frame is in RAM, so the downstream reader never starts a partial frame.
- Handles backpressure against the reader's pointer, abort, and oversize-frame drop.
- Single clock domain, wr_clk; the reader pointer arrives already in wr_clk.

---
 rtl/tx_ram_pkg.sv | 23 ++
 rtl/tx_ram_writer_if.sv | 43 ++++
 rtl/tx_ram_free_calc.sv | 28 ++
 rtl/tx_ram_writer.sv | 146 ++++++++++++++
 tb/tb_tx_ram_writer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_ram_pkg.sv
// rtl/tx_ram_pkg.sv - shared defaults and types for the TX RAM writer/reader pair
//
// Contents:
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH - default RAM geometry
//   DEF_PTR_WIDTH, ptr_width()      - pointer width: address plus one wrap bit
//   wr_state_e                      - writer state: WRITE or DROP
package tx_ram_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_PTR_WIDTH  = DEF_ADDR_WIDTH + 1;

  typedef enum logic {
    WRITE = 1'b0,
    DROP  = 1'b1
  } wr_state_e;

  // Pointers carry one bit above the address so full and empty differ.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/tx_ram_writer_if.sv
// rtl/tx_ram_writer_if.sv - stream, RAM write port and pointer bundle of the TX RAM writer
//
// Signals:
//   s_data/s_valid/s_last/s_abort/s_ready - framed input stream
//   ram_wr_data/ram_wr_addr/ram_wr_en     - RAM write port
//   rd_ptr                                - reader consumed pointer (wr_clk domain)
//   commit_ptr/frame_commit/frame_drop    - frame publication towards the reader
//   level                                 - words held in the buffer
// Modports: slave = the writer, master = the environment around it.
interface tx_ram_writer_if
  import tx_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_last;
  logic                  s_abort;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic                  ram_wr_en;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   commit_ptr;
  logic                  frame_commit;
  logic                  frame_drop;
  logic [ADDR_WIDTH:0]   level;

  modport slave (
    input  s_data, s_valid, s_last, s_abort, rd_ptr,
    output s_ready, ram_wr_data, ram_wr_addr, ram_wr_en,
           commit_ptr, frame_commit, frame_drop, level
  );

  modport master (
    output s_data, s_valid, s_last, s_abort, rd_ptr,
    input  s_ready, ram_wr_data, ram_wr_addr, ram_wr_en,
           commit_ptr, frame_commit, frame_drop, level
  );

endinterface

// File: rtl/tx_ram_free_calc.sv
// rtl/tx_ram_free_calc.sv - occupancy and full flag of a circular buffer from two wrap-bit pointers
//
// Ports:
//   wptr_i  - write pointer with wrap bit
//   rptr_i  - read pointer with wrap bit
//   level_o - words held, wptr_i - rptr_i
//   full_o  - no free slot left
module tx_ram_free_calc
  import tx_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH:0] wptr_i,
  input  logic [ADDR_WIDTH:0] rptr_i,
  output logic [ADDR_WIDTH:0] level_o,
  output logic                full_o
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH:0] free;

  // Modulo arithmetic over the wrap bit gives the right answer across wraps.
  assign level_o = wptr_i - rptr_i;
  assign free    = DEPTH - level_o;
  assign full_o  = (free == '0);

endmodule

// File: rtl/tx_ram_writer.sv
// rtl/tx_ram_writer.sv - write-side controller for the TX distributed SDP RAM
//
// Writes a framed stream into the RAM as a circular buffer and only publishes
// commit_ptr once the last word of a frame is inside the RAM.
// Ports:
//   wr_clk   - write clock, shared with the RAM write port
//   asyn_rst - asynchronous active-high reset
//   wr_if    - s_* stream in, ram_wr_* out, rd_ptr in,
//              commit_ptr/frame_commit/frame_drop/level out
module tx_ram_writer
  import tx_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_WORDS  = 256
) (
  input  logic           wr_clk,
  input  logic           asyn_rst,
  tx_ram_writer_if.slave wr_if
);

  localparam int            PW       = ptr_width(ADDR_WIDTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(MAX_WORDS - 1);

  wr_state_e             state_q, state_d;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         word_cnt_q, word_cnt_d;
  logic [PW-1:0]         commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]         pend_ptr_q, pend_ptr_d;
  logic                  pend_q, pend_d;
  logic                  frame_commit_q, frame_commit_d;
  logic                  frame_drop_q, frame_drop_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic [PW-1:0]         level;
  logic                  full;
  logic                  ready;
  logic                  accept;
  logic [PW-1:0]         rewind_ptr;

  tx_ram_free_calc #(.ADDR_WIDTH(ADDR_WIDTH)) u_free_calc (
    .wptr_i  (wptr_q),
    .rptr_i  (wr_if.rd_ptr),
    .level_o (level),
    .full_o  (full)
  );

  // DROP swallows beats without storing them, so it never backpressures.
  assign ready  = (state_q == DROP) || !full;
  assign accept = wr_if.s_valid && ready;

  // A frame whose last beat is still in the commit pipeline is already
  // complete, so a drop must not rewind past it.
  assign rewind_ptr = pend_q ? pend_ptr_q : commit_ptr_q;

  always_comb begin
    state_d        = state_q;
    wptr_d         = wptr_q;
    word_cnt_d     = word_cnt_q;
    commit_ptr_d   = commit_ptr_q;
    pend_d         = 1'b0;
    pend_ptr_d     = pend_ptr_q;
    frame_commit_d = 1'b0;
    frame_drop_d   = 1'b0;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;

    // Second commit stage: the RAM takes the last word on the same edge.
    if (pend_q) begin
      commit_ptr_d   = pend_ptr_q;
      frame_commit_d = 1'b1;
    end

    if (accept) begin
      if (state_q == WRITE) begin
        if (wr_if.s_abort) begin
          wptr_d       = rewind_ptr;
          word_cnt_d   = '0;
          frame_drop_d = 1'b1;
        end else if (!wr_if.s_last && (word_cnt_q == LAST_IDX)) begin
          wptr_d       = rewind_ptr;
          word_cnt_d   = '0;
          frame_drop_d = 1'b1;
          state_d      = DROP;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = wptr_q[ADDR_WIDTH-1:0];
          wr_data_d = wr_if.s_data;
          wptr_d    = wptr_q + 1'b1;
          if (wr_if.s_last) begin
            word_cnt_d = '0;
            pend_d     = 1'b1;
            pend_ptr_d = wptr_q + 1'b1;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end else if (wr_if.s_last || wr_if.s_abort) begin
        state_d    = WRITE;
        word_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge wr_clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      state_q        <= WRITE;
      wptr_q         <= '0;
      word_cnt_q     <= '0;
      commit_ptr_q   <= '0;
      pend_ptr_q     <= '0;
      pend_q         <= 1'b0;
      frame_commit_q <= 1'b0;
      frame_drop_q   <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      wptr_q         <= wptr_d;
      word_cnt_q     <= word_cnt_d;
      commit_ptr_q   <= commit_ptr_d;
      pend_ptr_q     <= pend_ptr_d;
      pend_q         <= pend_d;
      frame_commit_q <= frame_commit_d;
      frame_drop_q   <= frame_drop_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
    end
  end

  // Registers already clear on reset; the gate keeps s_ready low while it is held.
  assign wr_if.s_ready      = ready && !asyn_rst;
  assign wr_if.ram_wr_en    = wr_en_q;
  assign wr_if.ram_wr_addr  = wr_addr_q;
  assign wr_if.ram_wr_data  = wr_data_q;
  assign wr_if.commit_ptr   = commit_ptr_q;
  assign wr_if.frame_commit = frame_commit_q;
  assign wr_if.frame_drop   = frame_drop_q;
  assign wr_if.level        = level;

endmodule

// File: tb/tb_tx_ram_writer.sv
// tb/tb_tx_ram_writer.sv - self-checking bench for tx_ram_writer
module tb_tx_ram_writer;

  localparam int AW    = 4;
  localparam int DW    = 64;
  localparam int MW    = 8;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 16;
  localparam int NCYC  = 4096;

  logic wr_clk   = 1'b0;
  logic asyn_rst = 1'b0;

  tx_ram_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  tx_ram_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WORDS(MW)) dut (
    .wr_clk   (wr_clk),
    .asyn_rst (asyn_rst),
    .wr_if    (bus)
  );

  always #5 wr_clk = ~wr_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: frame bookkeeping plus per-cycle expected events.
  int            cyc = 0;
  logic [PW-1:0] m_wptr = '0;
  logic [PW-1:0] m_last_end = '0;
  logic [PW-1:0] m_commit_vis = '0;
  int            m_cnt = 0;
  bit            m_drop = 1'b0;

  bit            e_we   [NCYC];
  logic [AW-1:0] e_addr [NCYC];
  logic [DW-1:0] e_data [NCYC];
  bit            e_cp   [NCYC];
  logic [PW-1:0] e_cv   [NCYC];
  bit            e_drop [NCYC];

  int n_write  = 0;
  int n_commit = 0;
  int n_drop   = 0;

  always @(posedge wr_clk) begin
    logic [PW-1:0] lv;
    int c, c1;
    cyc++;
    c  = cyc % NCYC;
    c1 = (cyc + 1) % NCYC;
    if (asyn_rst) begin
      m_wptr = '0; m_last_end = '0; m_commit_vis = '0; m_cnt = 0; m_drop = 1'b0;
      e_we[c] = 0; e_cp[c] = 0; e_drop[c] = 0;
      e_we[c1] = 0; e_cp[c1] = 0; e_drop[c1] = 0;
    end else begin
      lv = m_wptr - bus.rd_ptr;
      if (bus.s_valid && (m_drop || lv != PW'(DEPTH))) begin
        if (m_drop) begin
          if (bus.s_last || bus.s_abort) m_drop = 1'b0;
        end else if (bus.s_abort) begin
          m_wptr = m_last_end; m_cnt = 0; e_drop[c] = 1;
        end else if (!bus.s_last && m_cnt == MW - 1) begin
          m_wptr = m_last_end; m_cnt = 0; e_drop[c] = 1; m_drop = 1'b1;
        end else begin
          e_we[c] = 1; e_addr[c] = m_wptr[AW-1:0]; e_data[c] = bus.s_data;
          m_wptr = m_wptr + 1'b1;
          if (bus.s_last) begin
            m_cnt = 0; m_last_end = m_wptr;
            e_cp[c1] = 1; e_cv[c1] = m_wptr;
          end else begin
            m_cnt++;
          end
        end
      end
    end
  end

  always @(posedge wr_clk) begin
    logic [PW-1:0] lv;
    bit            rdy;
    int c;
    #1;
    c = cyc % NCYC;
    if (!asyn_rst) begin
      if (e_cp[c]) m_commit_vis = e_cv[c];
      lv  = m_wptr - bus.rd_ptr;
      rdy = m_drop || (lv != PW'(DEPTH));
      chk("ram_wr_en", bus.ram_wr_en, e_we[c]);
      if (e_we[c]) begin
        chk("ram_wr_addr", bus.ram_wr_addr, e_addr[c]);
        chk("ram_wr_data", bus.ram_wr_data, e_data[c]);
      end
      chk("frame_commit", bus.frame_commit, e_cp[c]);
      chk("frame_drop", bus.frame_drop, e_drop[c]);
      chk("commit_ptr", bus.commit_ptr, m_commit_vis);
      chk("level", bus.level, lv);
      chk("s_ready", bus.s_ready, rdy);
      if (bus.ram_wr_en)    n_write++;
      if (bus.frame_commit) n_commit++;
      if (bus.frame_drop)   n_drop++;
    end
    e_we[c] = 0; e_cp[c] = 0; e_drop[c] = 0;
  end

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_abort = 1'b0;
    repeat (n) @(negedge wr_clk);
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic beat(input logic [63:0] d, input bit l, input bit a);
    int waitc = 0;
    bus.s_data  = d;
    bus.s_last  = l;
    bus.s_abort = a;
    bus.s_valid = 1'b1;
    #1;
    while (!bus.s_ready && waitc < 200) begin
      @(negedge wr_clk);
      #1;
      waitc++;
    end
    chk("accept_wait", (waitc < 200), 1);
    @(negedge wr_clk);
  endtask

  task automatic frame(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) beat(base + 64'(i), (i == n - 1), 1'b0);
  endtask

  task automatic do_reset();
    bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_abort = 1'b0;
    bus.s_data  = '0;   bus.rd_ptr = '0;
    asyn_rst = 1'b1;
    repeat (2) @(negedge wr_clk);
    asyn_rst = 1'b0;
    @(negedge wr_clk);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_s_ready"}, bus.s_ready, 0);
    chk({tag, "_ram_wr_en"}, bus.ram_wr_en, 0);
    chk({tag, "_ram_wr_addr"}, bus.ram_wr_addr, 0);
    chk({tag, "_ram_wr_data"}, bus.ram_wr_data, 0);
    chk({tag, "_commit_ptr"}, bus.commit_ptr, 0);
    chk({tag, "_frame_commit"}, bus.frame_commit, 0);
    chk({tag, "_frame_drop"}, bus.frame_drop, 0);
    chk({tag, "_level"}, bus.level, 0);
  endtask

  initial begin
    int w0, c0, d0;
    bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_abort = 1'b0;
    bus.s_data  = '0;   bus.rd_ptr = '0;
    #1 asyn_rst = 1'b1;
    #2 chk_zero_outputs("reset");
    @(negedge wr_clk);
    asyn_rst = 1'b0;
    @(negedge wr_clk);

    // Single 4-word frame.
    w0 = n_write; c0 = n_commit;
    frame(4, 64'h1);
    idle(4);
    chk("t1_commit_ptr", bus.commit_ptr, 4);
    chk("t1_level", bus.level, 4);
    chk("t1_commit_pulses", n_commit - c0, 1);
    chk("t1_writes", n_write - w0, 4);

    // Fill to 16, stall, then free space by advancing rd_ptr and wrap.
    do_reset();
    w0 = n_write;
    for (int i = 0; i < 16; i++) frame(1, 64'd100 + 64'(i));
    bus.s_data = 64'd116; bus.s_last = 1'b1; bus.s_abort = 1'b0; bus.s_valid = 1'b1;
    #1;
    chk("fill_s_ready", bus.s_ready, 0);
    chk("fill_level", bus.level, 16);
    repeat (4) @(negedge wr_clk);
    chk("fill_writes_stalled", n_write - w0, 16);
    bus.rd_ptr = 5'd5;
    for (int i = 16; i < 20; i++) frame(1, 64'd100 + 64'(i));
    idle(4);
    chk("fill_commit_wrapped", bus.commit_ptr, 5'b10100);
    chk("fill_level_after", bus.level, 15);

    // Accept in the same cycle rd_ptr advances at level 16.
    frame(1, 64'd120);
    chk("sim_level_before", bus.level, 16);
    bus.rd_ptr = 5'd6;
    beat(64'd121, 1'b1, 1'b0);
    bus.s_valid = 1'b0;
    #1;
    chk("sim_level_after", bus.level, 16);
    chk("sim_s_ready_after", bus.s_ready, 0);
    idle(3);

    // Abort mid-frame, then abort right behind an in-flight commit.
    do_reset();
    frame(2, 64'h200);
    idle(3);
    w0 = n_write; d0 = n_drop;
    beat(64'h210, 1'b0, 1'b0);
    beat(64'h211, 1'b0, 1'b0);
    beat(64'h212, 1'b0, 1'b1);
    idle(3);
    chk("abort_writes", n_write - w0, 2);
    chk("abort_drops", n_drop - d0, 1);
    chk("abort_commit_kept", bus.commit_ptr, 2);
    frame(2, 64'h220);
    idle(3);
    chk("abort_next_commit", bus.commit_ptr, 4);
    beat(64'h230, 1'b1, 1'b0);
    beat(64'h231, 1'b0, 1'b1);
    frame(1, 64'h240);
    idle(3);
    chk("inflight_abort_commit", bus.commit_ptr, 6);

    // Oversize 12-word frame, then a max-length and a short frame.
    do_reset();
    w0 = n_write; d0 = n_drop;
    for (int i = 0; i < 12; i++) beat(64'h300 + 64'(i), (i == 11), 1'b0);
    idle(3);
    chk("over_writes", n_write - w0, 7);
    chk("over_drops", n_drop - d0, 1);
    chk("over_commit_kept", bus.commit_ptr, 0);
    frame(MW, 64'h400);
    frame(3, 64'h500);
    idle(3);
    chk("over_after_commit", bus.commit_ptr, 11);

    // Asynchronous reset in the middle of a frame.
    beat(64'h600, 1'b0, 1'b0);
    beat(64'h601, 1'b0, 1'b0);
    #2;
    asyn_rst = 1'b1;
    bus.rd_ptr = '0;
    bus.s_valid = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    repeat (2) @(negedge wr_clk);
    asyn_rst = 1'b0;
    @(negedge wr_clk);
    beat(64'h700, 1'b0, 1'b0);
    chk("post_rst_addr", bus.ram_wr_addr, 0);
    chk("post_rst_en", bus.ram_wr_en, 1);
    beat(64'h701, 1'b1, 1'b0);
    idle(3);
    chk("post_rst_commit", bus.commit_ptr, 2);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "timeout");
  end

endmodule
